// File: rtl/code_convert_pkg.sv
// rtl/code_convert_pkg.sv - Binary/Gray pointer conversion helpers shared by the async FIFO controllers.
// Callers zero-extend their pointer to CC_MAX_W bits and size-cast the result back.
package code_convert_pkg;

  localparam int CC_MAX_W = 32;

  function automatic logic [CC_MAX_W-1:0] bin2gray(input logic [CC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits propagate as zeros, so any narrower Gray value converts correctly.
  function automatic logic [CC_MAX_W-1:0] gray2bin(input logic [CC_MAX_W-1:0] g);
    logic [CC_MAX_W-1:0] b;
    b[CC_MAX_W-1] = g[CC_MAX_W-1];
    for (int i = CC_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - Parameterized multi-flop synchronizer with async active-low reset to zero.
module sync_ff_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - Async FIFO read-side pointer/flag controller.
// Synchronizes the Gray write pointer and derives empty, almost_empty, occupancy and underflow.
module async_fifo_rd_ctrl
  import code_convert_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr_gray_i,
  input  logic              rd_en,
  output logic              pop,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(ALMOST_EMPTY_TH);

  logic [PTR_W-1:0] wq_gray;
  logic [PTR_W-1:0] wq_bin;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_next;
  logic [PTR_W-1:0] rd_gray_next;
  logic [PTR_W-1:0] count_next;

  sync_ff_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wr_ptr_gray_i),
    .q     (wq_gray)
  );

  assign wq_bin = PTR_W'(gray2bin(CC_MAX_W'(wq_gray)));

  assign pop          = rd_en & ~empty;
  assign rd_bin_next  = rd_bin + {{ADDR_W{1'b0}}, pop};
  assign rd_gray_next = PTR_W'(bin2gray(CC_MAX_W'(rd_bin_next)));
  assign count_next   = wq_bin - rd_bin_next;
  assign rd_addr      = rd_bin[ADDR_W-1:0];

  // Flags look at next-state pointers so a pop is reflected at the same edge it happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin       <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rd_bin       <= rd_bin_next;
      rd_ptr_gray  <= rd_gray_next;
      empty        <= (rd_gray_next == wq_gray);
      almost_empty <= (count_next <= AE_TH);
      rd_count     <= count_next;
      underflow    <= underflow | (rd_en & empty);
    end
  end

endmodule
